// File: rtl/io_pkg.sv
// Register map constants shared by the display/switch IO peripheral.
package io_pkg;
  localparam logic [3:0] ADDR_DISP = 4'h0;
  localparam logic [3:0] ADDR_STAT = 4'h4;
  localparam logic [3:0] ADDR_CTRL = 4'h8;

  localparam int CTRL_BLINK_BIT = 8;
  localparam int STAT_CHG_BIT   = 31;
endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus shared debounce counter for the slide switches.
// sw_chg pulses in the cycle sw_deb takes a new value.
module sw_debounce #(
  parameter int NUM_SW = 2,
  parameter int DEB_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_SW-1:0] SW,
  output logic [NUM_SW-1:0] sw_deb,
  output logic              sw_chg
);
  logic [NUM_SW-1:0] s1, s2;
  logic [DEB_W-1:0]  cnt;
  logic              settled, differs;

  // Counting only while the synchronised value is both new and steady means
  // any bounce restarts the full qualification window.
  assign settled = (s1 == s2);
  assign differs = (s2 != sw_deb);
  assign sw_chg  = differs && settled && (&cnt);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1     <= '0;
      s2     <= '0;
      cnt    <= '0;
      sw_deb <= '0;
    end else begin
      s1 <= SW;
      s2 <= s1;
      if (sw_chg) begin
        sw_deb <= s2;
        cnt    <= '0;
      end else if (differs && settled) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/io_display_ctrl.sv
// Memory-mapped IO peripheral: multiplexed 7-segment display with enable mask
// and blink, plus debounced slide switches with a sticky change flag.
module io_display_ctrl
  import io_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SEG_W      = 7,
  parameter int NUM_SW     = 2,
  parameter int DWELL_W    = 14,
  parameter int DEB_W      = 16,
  parameter int BLINK_W    = 22
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [3:0]            IOAddr,
  input  logic [31:0]           IOWriteData,
  input  logic                  IOWriteEn,
  input  logic                  IOReadEn,
  output logic [31:0]           IOReadData,
  input  logic [NUM_SW-1:0]     SW,
  output logic [NUM_DIGITS-1:0] AN,
  output logic [SEG_W-1:0]      SEG
);
  localparam int DW    = NUM_DIGITS * SEG_W;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [NUM_DIGITS-1:0][SEG_W-1:0] disp;
  logic [NUM_DIGITS-1:0]            mask;
  logic                             blink;
  logic                             chg_flag;
  logic [DWELL_W-1:0]               dwell_cnt;
  logic [IDX_W-1:0]                 idx;
  logic [BLINK_W-1:0]               blink_cnt;
  logic [NUM_SW-1:0]                sw_deb;
  logic                             sw_chg;
  logic                             digit_en;
  logic [NUM_DIGITS-1:0]            onehot;
  logic                             unused_wdata;

  assign unused_wdata = ^IOWriteData;

  sw_debounce #(.NUM_SW(NUM_SW), .DEB_W(DEB_W)) u_deb (
    .CLK    (CLK),
    .RESET  (RESET),
    .SW     (SW),
    .sw_deb (sw_deb),
    .sw_chg (sw_chg)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      disp  <= '0;
      mask  <= '1;
      blink <= 1'b0;
    end else if (IOWriteEn) begin
      case (IOAddr)
        ADDR_DISP: disp <= IOWriteData[DW-1:0];
        ADDR_CTRL: begin
          mask  <= IOWriteData[NUM_DIGITS-1:0];
          blink <= IOWriteData[CTRL_BLINK_BIT];
        end
        default: ;
      endcase
    end
  end

  // A new change in the same cycle as the clearing read must not be lost.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      chg_flag <= 1'b0;
    else if (sw_chg)
      chg_flag <= 1'b1;
    else if (IOReadEn && IOAddr == ADDR_STAT)
      chg_flag <= 1'b0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dwell_cnt <= '0;
      idx       <= '0;
      blink_cnt <= '0;
    end else begin
      dwell_cnt <= dwell_cnt + 1'b1;
      blink_cnt <= blink_cnt + 1'b1;
      if (&dwell_cnt)
        idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  assign digit_en = mask[idx] && !(blink && blink_cnt[BLINK_W-1]);
  assign onehot   = NUM_DIGITS'(1) << idx;
  assign AN       = digit_en ? ~onehot : '1;
  assign SEG      = digit_en ? ~disp[idx] : '1;

  always_comb begin
    IOReadData = '0;
    case (IOAddr)
      ADDR_DISP: IOReadData[DW-1:0] = disp;
      ADDR_STAT: begin
        IOReadData[STAT_CHG_BIT] = chg_flag;
        IOReadData[NUM_SW-1:0]   = sw_deb;
      end
      ADDR_CTRL: begin
        IOReadData[CTRL_BLINK_BIT]   = blink;
        IOReadData[NUM_DIGITS-1:0]   = mask;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_io_display_ctrl.sv
// Directed bench: a 4-digit instance for scan/blink/debounce/CHG/reset and a
// 3-digit instance for non-power-of-2 scan wrap and DISP width masking.
module tb_io_display_ctrl;
  logic        CLK, RESET;
  logic [3:0]  IOAddr;
  logic [31:0] IOWriteData, IOReadData;
  logic        IOWriteEn, IOReadEn;
  logic [1:0]  SW;
  logic [3:0]  AN;
  logic [6:0]  SEG;

  logic [3:0]  addr2;
  logic [31:0] wd2, rd2;
  logic        we2, re2;
  logic [1:0]  sw2;
  logic [2:0]  an2;
  logic [6:0]  seg2;

  int checks = 0;
  int errors = 0;
  int cyc;

  logic [6:0] dig [0:3];

  io_display_ctrl #(.NUM_DIGITS(4), .SEG_W(7), .NUM_SW(2), .DWELL_W(2), .DEB_W(3), .BLINK_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .IOAddr(IOAddr), .IOWriteData(IOWriteData),
    .IOWriteEn(IOWriteEn), .IOReadEn(IOReadEn), .IOReadData(IOReadData),
    .SW(SW), .AN(AN), .SEG(SEG)
  );

  io_display_ctrl #(.NUM_DIGITS(3), .SEG_W(7), .NUM_SW(2), .DWELL_W(1), .DEB_W(3), .BLINK_W(4)) dut3 (
    .CLK(CLK), .RESET(RESET), .IOAddr(addr2), .IOWriteData(wd2),
    .IOWriteEn(we2), .IOReadEn(re2), .IOReadData(rd2),
    .SW(sw2), .AN(an2), .SEG(seg2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Cycles since reset release; scan index and blink phase follow from it.
  always @(posedge CLK or posedge RESET) begin
    if (RESET) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    IOAddr = a; IOWriteData = d; IOWriteEn = 1'b1;
    tick();
    IOWriteEn = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    IOAddr = a;
    #1;
    chk(tag, IOReadData, exp);
  endtask

  // Check AN/SEG of the 4-digit instance against the scan/blink model.
  task automatic chk_scan4(input string tag, input logic [3:0] m, input logic bl);
    int         i;
    logic       en;
    logic [3:0] ea;
    logic [6:0] es;
    i  = (cyc >> 2) % 4;
    en = m[i] && !(bl && ((cyc >> 3) & 1) == 1);
    ea = en ? ~(4'b0001 << i) : 4'b1111;
    es = en ? ~dig[i] : 7'h7F;
    chk({tag, "_an"}, AN, ea);
    chk({tag, "_seg"}, SEG, es);
  endtask

  initial begin
    dig[0] = 7'h6F; dig[1] = 7'h1B; dig[2] = 7'h2F; dig[3] = 7'h05;
    RESET = 1'b1;
    IOAddr = '0; IOWriteData = '0; IOWriteEn = 1'b0; IOReadEn = 1'b0; SW = 2'b00;
    addr2 = '0; wd2 = '0; we2 = 1'b0; re2 = 1'b0; sw2 = 2'b00;
    tick(); tick();
    RESET = 1'b0;

    chk("rst_an", AN, 4'b1110);
    chk("rst_seg", SEG, 7'h7F);
    rd_chk("rst_disp", 4'h0, 32'h0);
    rd_chk("rst_stat", 4'h4, 32'h0);
    rd_chk("rst_ctrl", 4'h8, 32'h0000000F);

    // Write DISP while reading it: old value until the edge, new after.
    IOAddr = 4'h0; IOWriteData = 32'h00ABCDEF; IOWriteEn = 1'b1;
    #1 chk("wr_rd_old", IOReadData, 32'h0);
    tick();
    IOWriteEn = 1'b0;
    rd_chk("wr_rd_new", 4'h0, 32'h00ABCDEF);

    for (int k = 0; k < 16; k++) begin
      chk_scan4("scan", 4'hF, 1'b0);
      tick();
    end

    wr(4'hC, 32'hFFFFFFFF);
    rd_chk("unmap_disp", 4'h0, 32'h00ABCDEF);
    rd_chk("unmap_ctrl", 4'h8, 32'h0000000F);
    rd_chk("unmap_rd", 4'hC, 32'h0);

    // Blink with mask 0101.
    wr(4'h8, 32'h00000105);
    rd_chk("ctrl_rd", 4'h8, 32'h00000105);
    for (int k = 0; k < 16; k++) begin
      chk_scan4("blink", 4'h5, 1'b1);
      tick();
    end
    for (int k = 0; k < 16 && (cyc % 16) != 8; k++) tick();
    chk("blink_off_an", AN, 4'b1111);
    wr(4'h8, 32'h0000000F);
    chk_scan4("unblink", 4'hF, 1'b0);

    // Glitch on SW[0] shorter than the debounce window.
    SW = 2'b01;
    repeat (5) tick();
    SW = 2'b00;
    repeat (12) tick();
    rd_chk("glitch", 4'h4, 32'h0);

    SW = 2'b10;
    repeat (9) tick();
    rd_chk("deb_early", 4'h4, 32'h0);
    tick();
    rd_chk("deb_10", 4'h4, 32'h80000002);

    IOReadEn = 1'b1; IOAddr = 4'h4;
    tick();
    IOReadEn = 1'b0;
    rd_chk("chg_clr", 4'h4, 32'h00000002);

    // Clearing read coincides with a new debounced change.
    SW = 2'b00;
    repeat (9) tick();
    IOReadEn = 1'b1;
    rd_chk("chg_pre", 4'h4, 32'h00000002);
    tick();
    IOReadEn = 1'b0;
    rd_chk("chg_setwins", 4'h4, 32'h80000000);
    IOReadEn = 1'b1;
    tick();
    IOReadEn = 1'b0;
    rd_chk("chg_clr2", 4'h4, 32'h0);

    // 3-digit instance.
    addr2 = 4'h0; wd2 = 32'hFFFFFFFF; we2 = 1'b1;
    tick();
    we2 = 1'b0;
    #1 chk("d3_disp", rd2, 32'h001FFFFF);
    for (int k = 0; k < 12; k++) begin
      logic [2:0] ea;
      ea = ~(3'b001 << ((cyc >> 1) % 3));
      chk("d3_an", an2, ea);
      chk("d3_seg", seg2, 7'h00);
      tick();
    end

    // Reset in the middle of digit 2 and of a debounce.
    wr(4'h8, 32'h00000003);
    for (int k = 0; k < 16 && (cyc % 16) != 4; k++) tick();
    SW = 2'b01;
    repeat (4) tick();
    chk("pre_rst_an", AN, 4'b1111);
    #2 RESET = 1'b1;
    #1;
    chk("mid_rst_an", AN, 4'b1110);
    chk("mid_rst_seg", SEG, 7'h7F);
    rd_chk("mid_rst_stat", 4'h4, 32'h0);
    rd_chk("mid_rst_ctrl", 4'h8, 32'h0000000F);
    rd_chk("mid_rst_disp", 4'h0, 32'h0);
    tick();
    RESET = 1'b0;
    repeat (9) tick();
    rd_chk("post_rst_early", 4'h4, 32'h0);
    tick();
    rd_chk("post_rst_deb", 4'h4, 32'h80000001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
